lag_vector_tx: RTL and testbench
================================

// Module: lag_vector_tx
// PURPOSE
//  Producer end of the 36-bit lags / lags-valid interface feeding the lag-driven peripheral.
//  Consumes a per-microphone-pair correlation stream and runs one argmax tracker per pair.
//  When all three pairs have finished a frame, it packs the three peak lags into one word
//  and issues a single-cycle valid strobe.
//  Sits between the correlator datapath and the SOPC lags input conduit.
// PARAMETERS
//  LAG_W    12  signed lag width per pair; fixed so that 3*LAG_W = 36
//  CORR_W   32  signed correlation value width
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-high reset
//  corr_valid   in   1        correlation beat valid
//  corr_pair    in   2        pair index 0..2; value 3 is ignored
//  corr_lag     in   LAG_W    signed lag index of this beat
//  corr_value   in   CORR_W   signed correlation value of this beat
//  corr_last    in   1        last beat of this pair's frame
//  lags_out     out  36       {lag2, lag1, lag0}, two's complement
//  lags_valid   out  1        1-cycle strobe; lags_out is valid on that cycle and held until the next strobe
//  overrun      out  1        sticky: a pair completed twice before the word was emitted
//  overrun_clr  in   1        synchronous clear of overrun
// BEHAVIOUR
//  Reset (async, active-high):
//   - all trackers go to EMPTY; done flags = 0.
//   - lags_out = 0, lags_valid = 0, overrun = 0.
//  Per-pair tracker FSM (p = 0..2). An accepted beat has corr_valid=1 and corr_pair=p.
//   - EMPTY: accepted beat loads max_val <- corr_value and max_lag <- corr_lag.
//     Go to TRACKING, or to DONE if corr_last=1 (single-beat frame).
//   - TRACKING: accepted beat updates max only if corr_value > max_val (signed, strictly greater).
//     Ties therefore keep the earliest lag. If corr_last=1, the comparison is applied to this
//     beat first; then result[p] <- final max_lag, done[p] <- 1, go to EMPTY.
//   - Tracker register state is EMPTY or TRACKING; "DONE" is done[p]=1 with the tracker back in EMPTY,
//     so a new frame for p may start the next cycle.
//  Completion:
//   - Completing pair p while done[p]=1 overwrites result[p] with the newer lag and sets overrun=1.
//   - When done[0..2] are all 1 at the end of a cycle, on the next edge:
//     lags_out <- {result[2], result[1], result[0]}, lags_valid=1 for exactly 1 cycle,
//     and done[*] <- 0.
//   - Latency: lags_valid rises on the cycle after the clock edge that registers the last
//     completing corr_last beat.
//   - A pair completing in the same cycle that the word is emitted sets its done bit again
//     and belongs to the next word.
//  Other rules:
//   - Beats with corr_pair=3 or corr_valid=0 are ignored entirely, including corr_last.
//   - overrun_clr clears overrun. If overrun_clr and a new overrun event occur in the same
//     cycle, overrun stays 1 (set wins).
//   - There is no backpressure: the consumer must accept each strobe.
//   - Reset mid-frame discards partial maxima and done flags; no strobe is produced.
//   - No arithmetic overflow is possible: only compare and select are performed.
// TESTING
//  1. Pair0 values {5,9,9,2} at lags {-2,-1,0,1} (last on the 4th beat), then pair1 and pair2
//     single beats at lags 3 and -7 -> one strobe with lags_out={12'hFF9, 12'h003, 12'hFFF}.
//  2. Pair0 all values -100 (negative), 3 beats at lags 4,5,6 -> result[0]=4 (tie keeps earliest).
//  3. Pair1 completes twice (lags 2 then 6) before pair2 completes -> overrun=1,
//     emitted lag1 = 6; overrun_clr -> overrun=0.
//  4. Last beats for pair0, pair1 and pair2 interleaved on consecutive cycles -> exactly one
//     lags_valid pulse, 1 cycle after the pair2 last beat.
//  5. Assert reset mid-frame after pair0 and pair1 are done -> no strobe; a following full
//     frame yields only the new lags.
//  6. Beats on corr_pair=3 with corr_last=1 -> no state change, no strobe.

Source files
------------

// File: rtl/lag_vector_if.sv
// Bundle of the correlation beat stream and the packed lags output.
// The master side drives correlation beats. The slave side is the lag
// vector producer, which returns the packed lags, the strobe and the overrun flag.
interface lag_vector_if #(
  parameter int LAG_W  = 12,
  parameter int CORR_W = 32
);
  logic                     corr_valid;
  logic [1:0]               corr_pair;
  logic signed [LAG_W-1:0]  corr_lag;
  logic signed [CORR_W-1:0] corr_value;
  logic                     corr_last;
  logic [3*LAG_W-1:0]       lags_out;
  logic                     lags_valid;
  logic                     overrun;
  logic                     overrun_clr;

  modport master (
    output corr_valid, corr_pair, corr_lag, corr_value, corr_last, overrun_clr,
    input  lags_out, lags_valid, overrun
  );

  modport slave (
    input  corr_valid, corr_pair, corr_lag, corr_value, corr_last, overrun_clr,
    output lags_out, lags_valid, overrun
  );
endinterface

// File: rtl/lag_vector_tx.sv
// Lag vector producer: one argmax tracker per microphone pair. When all three
// pairs have finished a frame, the block packs {lag2, lag1, lag0} into one word
// and raises a single-cycle valid strobe.
module lag_vector_tx #(
  parameter int LAG_W  = 12,
  parameter int CORR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  lag_vector_if.slave bus
);

  typedef enum logic {
    EMPTY    = 1'b0,
    TRACKING = 1'b1
  } tracker_state_e;

  tracker_state_e           state_q   [3];
  tracker_state_e           state_d   [3];
  logic signed [CORR_W-1:0] max_val_q [3];
  logic signed [CORR_W-1:0] max_val_d [3];
  logic signed [LAG_W-1:0]  max_lag_q [3];
  logic signed [LAG_W-1:0]  max_lag_d [3];
  logic signed [LAG_W-1:0]  result_q  [3];
  logic signed [LAG_W-1:0]  result_d  [3];
  logic [2:0]               done_q;
  logic [2:0]               done_d;
  logic [3*LAG_W-1:0]       lags_out_q;
  logic [3*LAG_W-1:0]       lags_out_d;
  logic                     lags_valid_q;
  logic                     lags_valid_d;
  logic                     overrun_q;
  logic                     overrun_d;

  logic                     emit_s;
  logic                     ovr_event_s;
  logic [2:0]               hit_s;
  logic signed [LAG_W-1:0]  fin_lag_s [3];

  // Next-state logic for the trackers, the done flags, the word emission and the overrun flag.
  always_comb begin
    emit_s      = &done_q;
    ovr_event_s = 1'b0;
    hit_s       = 3'b000;
    for (int p = 0; p < 3; p++) begin
      state_d[p]   = state_q[p];
      max_val_d[p] = max_val_q[p];
      max_lag_d[p] = max_lag_q[p];
      result_d[p]  = result_q[p];
      fin_lag_s[p] = max_lag_q[p];
      // An emitted word clears done. A completion in the same cycle re-arms done for the next word.
      done_d[p]    = emit_s ? 1'b0 : done_q[p];
      hit_s[p]     = bus.corr_valid && (bus.corr_pair == 2'(p));

      if (hit_s[p]) begin
        case (state_q[p])
          EMPTY: begin
            max_val_d[p] = bus.corr_value;
            max_lag_d[p] = bus.corr_lag;
            fin_lag_s[p] = bus.corr_lag;
          end
          TRACKING: begin
            // Strictly greater keeps the earliest lag on ties.
            if (bus.corr_value > max_val_q[p]) begin
              max_val_d[p] = bus.corr_value;
              max_lag_d[p] = bus.corr_lag;
              fin_lag_s[p] = bus.corr_lag;
            end else begin
              fin_lag_s[p] = max_lag_q[p];
            end
          end
          default: begin
            fin_lag_s[p] = max_lag_q[p];
          end
        endcase

        if (bus.corr_last) begin
          state_d[p]  = EMPTY;
          result_d[p] = fin_lag_s[p];
          done_d[p]   = 1'b1;
          if (done_q[p] && !emit_s) begin
            ovr_event_s = 1'b1;
          end else begin
            ovr_event_s = ovr_event_s;
          end
        end else begin
          state_d[p] = TRACKING;
        end
      end else begin
        state_d[p] = state_q[p];
      end
    end

    lags_valid_d = emit_s;
    if (emit_s) begin
      lags_out_d = {result_q[2], result_q[1], result_q[0]};
    end else begin
      lags_out_d = lags_out_q;
    end

    // A set in the same cycle as a clear takes priority over the clear.
    overrun_d = (overrun_q && !bus.overrun_clr) || ovr_event_s;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        state_q[p]   <= EMPTY;
        max_val_q[p] <= '0;
        max_lag_q[p] <= '0;
        result_q[p]  <= '0;
      end
      done_q       <= 3'b000;
      lags_out_q   <= '0;
      lags_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        state_q[p]   <= state_d[p];
        max_val_q[p] <= max_val_d[p];
        max_lag_q[p] <= max_lag_d[p];
        result_q[p]  <= result_d[p];
      end
      done_q       <= done_d;
      lags_out_q   <= lags_out_d;
      lags_valid_q <= lags_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.lags_out   = lags_out_q;
  assign bus.lags_valid = lags_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_lag_vector_tx.sv
// Directed testbench for lag_vector_tx with hand-computed expected lag words.
module tb_lag_vector_tx;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lag_vector_if #(.LAG_W(12), .CORR_W(32)) bus ();

  lag_vector_tx #(.LAG_W(12), .CORR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat presented for one clock. Returns 1 time unit after the edge that samples it.
  task automatic beat(input logic [1:0] p, input int lag, input int val, input logic last);
    bus.corr_valid = 1'b1;
    bus.corr_pair  = p;
    bus.corr_lag   = 12'(lag);
    bus.corr_value = 32'(val);
    bus.corr_last  = last;
    @(posedge clk);
    #1;
    bus.corr_valid = 1'b0;
    bus.corr_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    reset = 1'b1;
    bus.corr_valid = 1'b0;
    bus.corr_pair = 2'd0;
    bus.corr_lag = 12'd0;
    bus.corr_value = 32'd0;
    bus.corr_last = 1'b0;
    bus.overrun_clr = 1'b0;
    #12;
    chk("reset_lags_out", bus.lags_out, 36'h0);
    chk("reset_valid", 36'(bus.lags_valid), 36'h0);
    chk("reset_overrun", 36'(bus.overrun), 36'h0);
    reset = 1'b0;
    idle();

    // 1: argmax with a tie, then two single-beat frames
    beat(2'd0, -2, 5, 1'b0);
    beat(2'd0, -1, 9, 1'b0);
    beat(2'd0, 0, 9, 1'b0);
    beat(2'd0, 1, 2, 1'b1);
    beat(2'd1, 3, 77, 1'b1);
    chk("t1_no_early_strobe", 36'(bus.lags_valid), 36'h0);
    beat(2'd2, -7, -3, 1'b1);
    chk("t1_strobe_latency", 36'(bus.lags_valid), 36'h0);
    idle();
    chk("t1_valid", 36'(bus.lags_valid), 36'h1);
    chk("t1_lags", bus.lags_out, 36'hFF9_003_FFF);
    idle();
    chk("t1_valid_drop", 36'(bus.lags_valid), 36'h0);
    chk("t1_lags_held", bus.lags_out, 36'hFF9_003_FFF);

    // 2: all-negative equal values keep the first lag
    beat(2'd0, 4, -100, 1'b0);
    beat(2'd0, 5, -100, 1'b0);
    beat(2'd0, 6, -100, 1'b1);
    beat(2'd1, 1, 0, 1'b1);
    beat(2'd2, 2, 0, 1'b1);
    idle();
    chk("t2_valid", 36'(bus.lags_valid), 36'h1);
    chk("t2_lags", bus.lags_out, 36'h002_001_004);
    idle();

    // 3: pair1 completes twice -> overrun, newer lag wins, then clear
    beat(2'd1, 2, 1, 1'b1);
    chk("t3_no_overrun_yet", 36'(bus.overrun), 36'h0);
    beat(2'd1, 6, 1, 1'b1);
    chk("t3_overrun_set", 36'(bus.overrun), 36'h1);
    beat(2'd0, 0, 1, 1'b1);
    beat(2'd2, -1, 1, 1'b1);
    idle();
    chk("t3_valid", 36'(bus.lags_valid), 36'h1);
    chk("t3_lags", bus.lags_out, 36'hFFF_006_000);
    chk("t3_overrun_sticky", 36'(bus.overrun), 36'h1);
    bus.overrun_clr = 1'b1;
    idle();
    bus.overrun_clr = 1'b0;
    chk("t3_overrun_clr", 36'(bus.overrun), 36'h0);

    // 4: interleaved frames, last beats on consecutive cycles
    beat(2'd0, 9, 1, 1'b0);
    beat(2'd1, 8, 1, 1'b0);
    beat(2'd2, 7, 1, 1'b0);
    beat(2'd0, 10, 5, 1'b1);
    chk("t4_valid_a", 36'(bus.lags_valid), 36'h0);
    beat(2'd1, -8, 0, 1'b1);
    chk("t4_valid_b", 36'(bus.lags_valid), 36'h0);
    beat(2'd2, -2048, 3, 1'b1);
    chk("t4_valid_c", 36'(bus.lags_valid), 36'h0);
    idle();
    chk("t4_valid_pulse", 36'(bus.lags_valid), 36'h1);
    chk("t4_lags", bus.lags_out, 36'h800_008_00A);
    idle();
    chk("t4_single_pulse", 36'(bus.lags_valid), 36'h0);
    chk("t4_overrun", 36'(bus.overrun), 36'h0);

    // 5: reset mid-frame drops done flags and partial maxima
    beat(2'd0, 1, 1, 1'b1);
    beat(2'd1, 2, 1, 1'b1);
    beat(2'd2, 3, 0, 1'b0);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    idle();
    chk("t5_reset_lags", bus.lags_out, 36'h0);
    beat(2'd2, 5, -5, 1'b1);
    idle();
    chk("t5_no_strobe", 36'(bus.lags_valid), 36'h0);
    beat(2'd0, -1, 0, 1'b1);
    beat(2'd1, -2, 0, 1'b1);
    idle();
    chk("t5_valid", 36'(bus.lags_valid), 36'h1);
    chk("t5_lags", bus.lags_out, 36'h005_FFE_FFF);
    idle();

    // 6: pair index 3 and invalid beats are ignored, including their last flag
    beat(2'd3, 100, 50, 1'b1);
    beat(2'd3, 101, 50, 1'b1);
    bus.corr_valid = 1'b0;
    bus.corr_pair = 2'd0;
    bus.corr_lag = 12'd100;
    bus.corr_last = 1'b1;
    idle();
    bus.corr_last = 1'b0;
    idle();
    chk("t6_no_strobe_a", 36'(bus.lags_valid), 36'h0);
    beat(2'd0, 7, 1, 1'b1);
    beat(2'd1, 8, 1, 1'b1);
    idle();
    chk("t6_no_strobe_b", 36'(bus.lags_valid), 36'h0);
    chk("t6_no_overrun", 36'(bus.overrun), 36'h0);
    beat(2'd2, 9, 1, 1'b1);
    idle();
    chk("t6_valid", 36'(bus.lags_valid), 36'h1);
    chk("t6_lags", bus.lags_out, 36'h009_008_007);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
